logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter_pkg.sv | 19 +
 rtl/logic_op_core.sv | 24 ++
 rtl/logic_unit_arbiter.sv | 114 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types for the two-requester logic unit: opcode and FSM state encodings.
package logic_unit_arbiter_pkg;

  localparam int unsigned OpWidth = 2;

  typedef enum logic [OpWidth-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NOTA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational bitwise function unit shared by both requesters.
module logic_op_core
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  op_e          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a single logic unit: accept, execute, report,
// one operation at a time.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [OpWidth-1:0] op0,
  input  logic [OpWidth-1:0] op1,
  input  logic [N-1:0]       a0,
  input  logic [N-1:0]       b0,
  input  logic [N-1:0]       a1,
  input  logic [N-1:0]       b1,
  output logic               ack0,
  output logic               ack1,
  output logic               done0,
  output logic               done1,
  output logic [N-1:0]       y,
  output logic               busy
);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         owner_q, owner_d;
  op_e          op_q, op_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] y_q, y_d;
  logic [N-1:0] f_y;
  logic         winner;

  logic_op_core #(
    .N(N)
  ) u_core (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (f_y)
  );

  // Pointer breaks ties only; a lone request wins outright.
  always_comb begin
    if (req0 && req1) begin
      winner = ptr_q;
    end else begin
      winner = req1 && !req0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          ptr_d   = ~winner;
          op_d    = winner ? op_e'(op1) : op_e'(op0);
          a_d     = winner ? a1 : a0;
          b_d     = winner ? b1 : b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d     = f_y;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  // Pulses decode straight from state so an asynchronous reset clears them at once.
  assign ack0  = (state_q == EXEC) && !owner_q;
  assign ack1  = (state_q == EXEC) && owner_q;
  assign done0 = (state_q == DONE) && !owner_q;
  assign done1 = (state_q == DONE) && owner_q;
  assign busy  = (state_q != IDLE);
  assign y     = y_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter at N=4.
module tb_logic_unit_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, done0, done1, busy;
  logic [N-1:0] y;

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] y_model = '0;

  // {ack0, ack1, done0, done1, busy}
  localparam logic [4:0] PIdle  = 5'b00000;
  localparam logic [4:0] PAck0  = 5'b10001;
  localparam logic [4:0] PAck1  = 5'b01001;
  localparam logic [4:0] PDone0 = 5'b00101;
  localparam logic [4:0] PDone1 = 5'b00011;

  logic_unit_arbiter #(
    .N(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .req1 (req1),
    .op0  (op0),
    .op1  (op1),
    .a0   (a0),
    .b0   (b0),
    .a1   (a1),
    .b1   (b1),
    .ack0 (ack0),
    .ack1 (ack1),
    .done0(done0),
    .done1(done1),
    .y    (y),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pulses();
    return {3'b000, ack0, ack1, done0, done1, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one lone request and check the full accept/execute/report sequence.
  task automatic run_op(input bit who, input logic [1:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] exp_y, input string tag);
    if (who) begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, "_ack"}, pulses(), who ? PAck1 : PAck0);
    check({tag, "_yhold"}, 8'(y), 8'(y_model));
    tick();
    check({tag, "_done"}, pulses(), who ? PDone1 : PDone0);
    check({tag, "_y"}, 8'(y), 8'(exp_y));
    y_model = exp_y;
    tick();
    check({tag, "_idle"}, pulses(), PIdle);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("rst_pulses", pulses(), PIdle);
    check("rst_y", 8'(y), 8'h0);
    y_model = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();

    // Single request, AND
    run_op(1'b0, 2'b00, 4'b1100, 4'b1010, 4'b1000, "and0");

    // Remaining opcodes through requester 1
    run_op(1'b1, 2'b01, 4'b1100, 4'b1010, 4'b1110, "or1");
    run_op(1'b1, 2'b11, 4'b1100, 4'b1010, 4'b0011, "nota1");
    run_op(1'b1, 2'b10, 4'b1100, 4'b1010, 4'b0110, "xor1");

    // Idle hold after result 0110
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_pulses", pulses(), PIdle);
      check("hold_y", 8'(y), 8'b0110);
    end

    // Operand change during the ack cycle must not disturb the result
    req0 = 1'b1; op0 = 2'b00; a0 = 4'b1111; b0 = 4'b1111;
    tick();
    check("opchg_ack", pulses(), PAck0);
    a0 = 4'b0000;
    req0 = 1'b0;
    tick();
    check("opchg_done", pulses(), PDone0);
    check("opchg_y", 8'(y), 8'b1111);
    tick();
    y_model = 4'b1111;

    // Reset in EXEC discards the operation
    req0 = 1'b1; op0 = 2'b01; a0 = 4'b0001; b0 = 4'b0010;
    tick();
    req0 = 1'b0;
    check("midrst_exec", pulses(), PAck0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pulses", pulses(), PIdle);
    check("midrst_y", 8'(y), 8'h0);
    y_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_nodone", pulses(), PIdle);
      check("midrst_y0", 8'(y), 8'h0);
    end
    run_op(1'b1, 2'b10, 4'b0101, 4'b0011, 4'b0110, "postrst");

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    req0 = 1'b1; op0 = 2'b00; a0 = 4'b1100; b0 = 4'b1010;
    req1 = 1'b1; op1 = 2'b10; a1 = 4'b1100; b1 = 4'b1010;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      automatic bit w = bit'((i / 3) % 2);
      automatic logic [7:0] exp_p;
      tick();
      case (i % 3)
        0:       exp_p = w ? PAck1 : PAck0;
        1:       exp_p = w ? PDone1 : PDone0;
        default: exp_p = PIdle;
      endcase
      check("cont_pulses", pulses(), exp_p);
      if (i % 3 == 1) check("cont_y", 8'(y), w ? 8'b0110 : 8'b1000);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("cont_end", pulses(), PIdle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Mutual exclusion of pulses throughout the run
  always @(negedge clk) begin
    if ((ack0 && ack1) || (done0 && done1)) begin
      n_vec++;
      n_err++;
      $display("FAIL excl: ack=%b%b done=%b%b expected no overlap", ack0, ack1, done0, done1);
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
